// File: rtl/vga_color_source.sv
// Cell-mapped color source feeding the VGA sync generator: 80x60 map of 8x8 px cells.
// Optional VGA_TEST_PATTERN_EN adds iPatternEn, which replaces map data with vertical color bars.
module vga_color_source #(
   parameter int unsigned H_CELLS    = 80,
   parameter int unsigned V_CELLS    = 60,
   parameter int unsigned CELL_SHIFT = 3,
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned COLOR_W    = 3
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iFrameStart,
   input  logic               iLineEnd,
   input  logic               iPixelValid,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               iPatternEn,
`endif
   input  logic               iWrEn,
   input  logic [ADDR_W-1:0]  iWrAddr,
   input  logic [COLOR_W-1:0] iWrColor,
   output logic               oWrReady,
   output logic [COLOR_W-1:0] oColor,
   output logic               oColorValid
);

   localparam int unsigned MapCells = H_CELLS * V_CELLS;
   localparam int unsigned ColW     = $clog2(H_CELLS + 1);
   localparam int unsigned RowW     = $clog2(V_CELLS + 1);

   // col == H_CELLS / row == V_CELLS are the saturated overrun states.
   localparam logic [ColW-1:0]       ColEnd   = ColW'(H_CELLS);
   localparam logic [RowW-1:0]       RowEnd   = RowW'(V_CELLS);
   localparam logic [CELL_SHIFT-1:0] SubMax   = '1;
   localparam logic [ADDR_W-1:0]     LineStep = ADDR_W'(H_CELLS);
   localparam logic [ADDR_W:0]       MapLimit = (ADDR_W + 1)'(MapCells);

   logic [COLOR_W-1:0] map_q [MapCells];

   logic [CELL_SHIFT-1:0] sub_x_q, sub_x_d;
   logic [CELL_SHIFT-1:0] sub_y_q, sub_y_d;
   logic [ColW-1:0]       col_q, col_d;
   logic [RowW-1:0]       row_q, row_d;
   logic [ADDR_W-1:0]     line_base_q, line_base_d;
   logic [COLOR_W-1:0]    color_q, color_d;
   logic                  color_valid_q, color_valid_d;

   logic                  pix_overrun;
   logic [ADDR_W-1:0]     rd_addr;
   logic [COLOR_W-1:0]    map_rd;
   logic                  wr_fire;

   assign oWrReady = ~iPixelValid;
   assign wr_fire  = iWrEn & ~iPixelValid & ({1'b0, iWrAddr} < MapLimit);

   always_comb begin
      sub_x_d     = sub_x_q;
      sub_y_d     = sub_y_q;
      col_d       = col_q;
      row_d       = row_q;
      line_base_d = line_base_q;
      if (iFrameStart) begin
         sub_x_d     = '0;
         sub_y_d     = '0;
         col_d       = '0;
         row_d       = '0;
         line_base_d = '0;
      end else if (iLineEnd) begin
         sub_x_d = '0;
         col_d   = '0;
         if (row_q != RowEnd) begin
            sub_y_d = sub_y_q + CELL_SHIFT'(1);
            if (sub_y_q == SubMax) begin
               row_d       = row_q + RowW'(1);
               line_base_d = line_base_q + LineStep;
            end
         end
      end else if (iPixelValid && (col_q != ColEnd)) begin
         sub_x_d = sub_x_q + CELL_SHIFT'(1);
         if (sub_x_q == SubMax) begin
            col_d = col_q + ColW'(1);
         end
      end
   end

   assign pix_overrun = (col_q == ColEnd) || (row_q == RowEnd);
   assign rd_addr     = line_base_q + ADDR_W'(col_q);
   assign map_rd      = map_q[rd_addr];

   always_comb begin
      color_d       = '0;
      color_valid_d = iPixelValid;
      if (iPixelValid && !pix_overrun) begin
`ifdef VGA_TEST_PATTERN_EN
         color_d = iPatternEn ? COLOR_W'(col_q[2:0]) : map_rd;
`else
         color_d = map_rd;
`endif
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sub_x_q       <= '0;
         sub_y_q       <= '0;
         col_q         <= '0;
         row_q         <= '0;
         line_base_q   <= '0;
         color_q       <= '0;
         color_valid_q <= 1'b0;
      end else begin
         sub_x_q       <= sub_x_d;
         sub_y_q       <= sub_y_d;
         col_q         <= col_d;
         row_q         <= row_d;
         line_base_q   <= line_base_d;
         color_q       <= color_d;
         color_valid_q <= color_valid_d;
      end
   end

   // The map survives reset; only the write port touches it.
   always_ff @(posedge Clock) begin
      if (wr_fire) begin
         map_q[iWrAddr] <= iWrColor;
      end
   end

   assign oColor      = color_q;
   assign oColorValid = color_valid_q;

endmodule

// File: tb/tb_vga_color_source.sv
// Directed bench for vga_color_source: map write/read, line base stepping, write blocking,
// overrun, asynchronous reset mid-line and, with VGA_TEST_PATTERN_EN, the color bars.
module tb_vga_color_source;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        iFrameStart = 1'b0;
   logic        iLineEnd = 1'b0;
   logic        iPixelValid = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
   logic        iPatternEn = 1'b0;
`endif
   logic        iWrEn = 1'b0;
   logic [12:0] iWrAddr = '0;
   logic [2:0]  iWrColor = '0;
   logic        oWrReady;
   logic [2:0]  oColor;
   logic        oColorValid;

   int n_checks = 0;
   int n_fail   = 0;

   vga_color_source dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iFrameStart (iFrameStart),
      .iLineEnd    (iLineEnd),
      .iPixelValid (iPixelValid),
`ifdef VGA_TEST_PATTERN_EN
      .iPatternEn  (iPatternEn),
`endif
      .iWrEn       (iWrEn),
      .iWrAddr     (iWrAddr),
      .iWrColor    (iWrColor),
      .oWrReady    (oWrReady),
      .oColor      (oColor),
      .oColorValid (oColorValid)
   );

   always #5 Clock = ~Clock;

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic wr(input logic [12:0] a, input logic [2:0] c);
      iWrAddr  = a;
      iWrColor = c;
      iWrEn    = 1'b1;
      cyc();
      iWrEn    = 1'b0;
   endtask

   task automatic frame();
      iFrameStart = 1'b1;
      cyc();
      iFrameStart = 1'b0;
   endtask

   task automatic line_end();
      iLineEnd = 1'b1;
      cyc();
      iLineEnd = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if (oColor !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_color: got %b want 000", oColor);
      end
      n_checks++;
      if (oColorValid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", oColorValid);
      end
      cyc();
      Reset = 1'b1;
      cyc();
   endtask

   task automatic test_write_read();
      logic [2:0] exp;
      iWrEn = 1'b1;
      #1;
      n_checks++;
      if (oWrReady !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready_idle: got %b want 1", oWrReady);
      end
      iWrEn = 1'b0;
      wr(13'd0, 3'b100);
      wr(13'd1, 3'b010);
      frame();
      iPixelValid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc();
         exp = (i < 8) ? 3'b100 : 3'b010;
         n_checks++;
         if (oColor !== exp || oColorValid !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_px%0d: got %b/%b want %b/1", i, oColor, oColorValid, exp);
         end
      end
      iPixelValid = 1'b0;
      cyc();
      n_checks++;
      if (oColor !== 3'b000 || oColorValid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_px: got %b/%b want 000/0", oColor, oColorValid);
      end
      line_end();
   endtask

   task automatic test_line_base();
      wr(13'd80, 3'b001);
      frame();
      repeat (7) line_end();
      iPixelValid = 1'b1;
      cyc();
      iPixelValid = 1'b0;
      n_checks++;
      if (oColor !== 3'b100) begin
         n_fail++;
         $display("FAIL line7_px0: got %b want 100", oColor);
      end
      line_end();
      iPixelValid = 1'b1;
      cyc();
      iPixelValid = 1'b0;
      n_checks++;
      if (oColor !== 3'b001 || oColorValid !== 1'b1) begin
         n_fail++;
         $display("FAIL line8_px0: got %b/%b want 001/1", oColor, oColorValid);
      end
      cyc();
   endtask

   task automatic test_write_blocked();
      frame();
      iPixelValid = 1'b1;
      iWrEn       = 1'b1;
      iWrAddr     = 13'd0;
      iWrColor    = 3'b111;
      #1;
      n_checks++;
      if (oWrReady !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_ready_busy: got %b want 0", oWrReady);
      end
      cyc();
      n_checks++;
      if (oColor !== 3'b100) begin
         n_fail++;
         $display("FAIL blocked_px0: got %b want 100", oColor);
      end
      cyc();
      n_checks++;
      if (oColor !== 3'b100) begin
         n_fail++;
         $display("FAIL blocked_px1: got %b want 100", oColor);
      end
      iPixelValid = 1'b0;
      #1;
      n_checks++;
      if (oWrReady !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready_release: got %b want 1", oWrReady);
      end
      cyc();
      iWrEn = 1'b0;
      frame();
      iPixelValid = 1'b1;
      cyc();
      iPixelValid = 1'b0;
      n_checks++;
      if (oColor !== 3'b111) begin
         n_fail++;
         $display("FAIL held_write_done: got %b want 111", oColor);
      end
      cyc();
   endtask

   task automatic test_overrun();
      wr(13'd4800, 3'b101);
      wr(13'd4720, 3'b110);
      wr(13'd4799, 3'b011);
      frame();
      iPixelValid = 1'b1;
      for (int i = 0; i < 648; i++) begin
         cyc();
         if (i == 0 || i == 8 || i >= 640) begin
            n_checks++;
            if (oColor !== ((i == 0) ? 3'b111 : (i == 8) ? 3'b010 : 3'b000)
                || oColorValid !== 1'b1) begin
               n_fail++;
               $display("FAIL col_ovr_px%0d: got %b/%b", i, oColor, oColorValid);
            end
         end
      end
      iPixelValid = 1'b0;
      line_end();
      repeat (478) line_end();
      iPixelValid = 1'b1;
      for (int i = 0; i < 641; i++) begin
         cyc();
         if (i == 0 || i >= 632) begin
            n_checks++;
            if (oColor !== ((i == 0) ? 3'b110 : (i < 640) ? 3'b011 : 3'b000)
                || oColorValid !== 1'b1) begin
               n_fail++;
               $display("FAIL line479_px%0d: got %b/%b", i, oColor, oColorValid);
            end
         end
      end
      iPixelValid = 1'b0;
      line_end();
      iPixelValid = 1'b1;
      cyc();
      iPixelValid = 1'b0;
      n_checks++;
      if (oColor !== 3'b000 || oColorValid !== 1'b1) begin
         n_fail++;
         $display("FAIL row_ovr: got %b/%b want 000/1", oColor, oColorValid);
      end
      cyc();
      n_checks++;
      if (oColorValid !== 1'b0) begin
         n_fail++;
         $display("FAIL row_ovr_idle: got %b want 0", oColorValid);
      end
   endtask

   task automatic test_mid_reset();
      frame();
      iPixelValid = 1'b1;
      repeat (3) cyc();
      Reset = 1'b0;
      #1;
      n_checks++;
      if (oColor !== 3'b000 || oColorValid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %b/%b want 000/0", oColor, oColorValid);
      end
      cyc();
      n_checks++;
      if (oColor !== 3'b000 || oColorValid !== 1'b0) begin
         n_fail++;
         $display("FAIL held_reset: got %b/%b want 000/0", oColor, oColorValid);
      end
      Reset = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         if (i == 0 || i == 8) begin
            n_checks++;
            if (oColor !== ((i == 0) ? 3'b111 : 3'b010) || oColorValid !== 1'b1) begin
               n_fail++;
               $display("FAIL post_reset_px%0d: got %b/%b", i, oColor, oColorValid);
            end
         end
      end
      iPixelValid = 1'b0;
      cyc();
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern();
      logic [2:0] exp;
      iPatternEn = 1'b1;
      frame();
      iPixelValid = 1'b1;
      for (int i = 0; i < 65; i++) begin
         cyc();
         exp = 3'((i / 8) % 8);
         n_checks++;
         if (oColor !== exp || oColorValid !== 1'b1) begin
            n_fail++;
            $display("FAIL pattern_px%0d: got %b/%b want %b/1", i, oColor, oColorValid, exp);
         end
      end
      iPixelValid = 1'b0;
      iPatternEn  = 1'b0;
      cyc();
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_line_base();
      test_write_blocked();
      test_overrun();
      test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
